seg_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver for the board top level. It replaces the fixed 4-digit scan logic with a generic N-digit scanner. Features: hex or raw-segment mode, per-digit blanking and decimal points, anti-ghosting blank interval, and tear-free double-buffered input loading. It drives the board anode, segment and dp pins directly.

---
 rtl/seg_pkg.sv | 38 +++
 rtl/seg_scan_timer.sv | 45 ++++
 rtl/seg_scan_driver.sv | 123 ++++++++++++
 tb/tb_seg_scan_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and the hex font for the multiplexed seven-segment scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a}, with 1 meaning the segment is lit.
package seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'b0000000;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_SHOW  = 1'b1
   } scan_phase_e;

   function automatic seg_t hex2seg(input logic [3:0] nib);
      seg_t s;
      case (nib)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         4'hF: s = 7'b1110001;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: the cycle counter within a slot and the index of the digit being scanned.
// frame_done is registered so it lines up with the registered pins in the top level.
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int DIV          = 10,
   parameter int BLANK_CYCLES = 2,
   localparam int SW          = (DIGITS > 1) ? $clog2(DIGITS) : 1,
   localparam int CW          = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic          clk,
   input  logic          rst,
   output logic [SW-1:0] scan_idx,
   output scan_phase_e   phase,
   output logic          boundary,
   output logic          frame_done
);

   logic [CW-1:0] cnt;
   logic          last_cnt;
   logic          last_idx;

   assign last_cnt = (cnt == CW'(DIV - 1));
   assign last_idx = (scan_idx == SW'(DIGITS - 1));
   assign boundary = last_cnt && last_idx;
   assign phase    = (cnt < CW'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         scan_idx   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (last_cnt) begin
            cnt      <= '0;
            scan_idx <= last_idx ? '0 : scan_idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Generic N-digit multiplexed seven-segment driver with blank interval and a
// double-buffered input so that a frame never mixes two loads.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int CLK_HZ       = 100_000_000,
   parameter int SLOT_HZ      = 1000,
   parameter int BLANK_CYCLES = 16,
   parameter int ACTIVE_LOW   = 1,
   localparam int SW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  raw_mode,
   input  logic [7*DIGITS-1:0]   raw_seg,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [SW-1:0]         scan_idx,
   output logic                  frame_done
);

   localparam int   DIV = CLK_HZ / SLOT_HZ;
   localparam logic POL = (ACTIVE_LOW != 0);

   if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
      $error("seg_scan_driver: DIGITS must be in 1..16");
   end
   if (BLANK_CYCLES >= DIV) begin : g_bad_blank
      $error("seg_scan_driver: BLANK_CYCLES must be smaller than CLK_HZ/SLOT_HZ");
   end

   typedef struct packed {
      logic                    raw;
      logic [DIGITS-1:0]       blank;
      logic [DIGITS-1:0]       dp;
      logic [DIGITS-1:0][3:0]  nib;
      logic [DIGITS-1:0][6:0]  rseg;
   } dbuf_t;

   // Reset leaves every digit dark until a real load reaches a frame boundary.
   localparam dbuf_t BUF_RST = '{raw: 1'b0, blank: '1, dp: '0, nib: '0, rseg: '0};

   scan_phase_e              phase;
   logic                     boundary;
   dbuf_t                    in_buf, pend, shad;
   logic                     pend_valid;
   logic [DIGITS-1:0][6:0]   dig_seg;
   logic [DIGITS-1:0]        lit_an;
   seg_t                     lit_seg;
   logic                     lit_dp;

   seg_scan_timer #(
      .DIGITS       (DIGITS),
      .DIV          (DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .scan_idx   (scan_idx),
      .phase      (phase),
      .boundary   (boundary),
      .frame_done (frame_done)
   );

   assign in_buf = '{raw: raw_mode, blank: blank_in, dp: dp_in, nib: data, rseg: raw_seg};

   // A load in the boundary cycle bypasses pending so it lands in the very next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend       <= BUF_RST;
         shad       <= BUF_RST;
         pend_valid <= 1'b0;
      end else begin
         if (load)
            pend <= in_buf;
         if (boundary) begin
            if (load)
               shad <= in_buf;
            else if (pend_valid)
               shad <= pend;
            pend_valid <= 1'b0;
         end else if (load) begin
            pend_valid <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_lane
      assign dig_seg[i] = shad.raw ? shad.rseg[i] : hex2seg(shad.nib[i]);
   end

   always_comb begin
      lit_an  = '0;
      lit_seg = SEG_OFF;
      lit_dp  = 1'b0;
      if (phase == PH_SHOW) begin
         lit_seg = dig_seg[scan_idx];
         lit_dp  = shad.dp[scan_idx];
         for (int i = 0; i < DIGITS; i++)
            if (scan_idx == SW'(i) && !shad.blank[i])
               lit_an[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= {DIGITS{POL}};
         seg <= {7{POL}};
         dp  <= POL;
      end else begin
         an  <= lit_an ^ {DIGITS{POL}};
         seg <= lit_seg ^ {7{POL}};
         dp  <= lit_dp ^ POL;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver (4 digits, 10-cycle slots, 2 blank cycles, active-low)
// against a frame/slot arithmetic model, plus literal pin checks for the directed scenarios.
module tb_seg_scan_driver;

   localparam int D   = 4;
   localparam int DIV = 10;
   localparam int BC  = 2;
   localparam int FR  = D * DIV;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           load = 1'b0;
   logic [4*D-1:0] data = '0;
   logic [D-1:0]   dp_in = '0;
   logic [D-1:0]   blank_in = '0;
   logic           raw_mode = 1'b0;
   logic [7*D-1:0] raw_seg = '0;
   logic [D-1:0]   an;
   logic [6:0]     seg;
   logic           dp;
   logic [1:0]     scan_idx;
   logic           frame_done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .DIGITS(D), .CLK_HZ(1000), .SLOT_HZ(100), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .blank_in(blank_in),
      .raw_mode(raw_mode), .raw_seg(raw_seg), .an(an), .seg(seg), .dp(dp),
      .scan_idx(scan_idx), .frame_done(frame_done)
   );

   logic [6:0] font [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

   // Model: m_k counts clock edges since reset release; slot/cnt follow by division.
   int             m_k = 0;
   int             mc, ms;
   logic           mp_v = 1'b0;
   logic [4*D-1:0] mp_data = '0, sh_data = '0;
   logic [D-1:0]   mp_dp = '0, sh_dp = '0;
   logic [D-1:0]   mp_blank = '1, sh_blank = '1;
   logic           mp_raw = 1'b0, sh_raw = 1'b0;
   logic [7*D-1:0] mp_rseg = '0, sh_rseg = '0;
   logic [6:0]     m_lit;
   logic [D-1:0]   e_an = '1;
   logic [6:0]     e_seg = '1;
   logic           e_dp = 1'b1;
   logic           e_fd = 1'b0;
   int             e_idx = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_k = 0; mp_v = 1'b0;
         mp_data = '0; mp_dp = '0; mp_blank = '1; mp_raw = 1'b0; mp_rseg = '0;
         sh_data = '0; sh_dp = '0; sh_blank = '1; sh_raw = 1'b0; sh_rseg = '0;
         e_an = '1; e_seg = '1; e_dp = 1'b1; e_fd = 1'b0; e_idx = 0;
      end else begin
         mc = m_k % DIV;
         ms = (m_k / DIV) % D;
         m_lit = sh_raw ? sh_rseg[7*ms +: 7] : font[sh_data[4*ms +: 4]];
         e_fd = (mc == DIV-1) && (ms == D-1);
         if (mc < BC) begin
            e_an = '1; e_seg = '1; e_dp = 1'b1;
         end else begin
            e_an  = sh_blank[ms] ? {D{1'b1}} : ~(D'(1) << ms);
            e_seg = ~m_lit;
            e_dp  = ~sh_dp[ms];
         end
         if (load) begin
            mp_data = data; mp_dp = dp_in; mp_blank = blank_in; mp_raw = raw_mode;
            mp_rseg = raw_seg; mp_v = 1'b1;
         end
         if (e_fd) begin
            if (mp_v) begin
               sh_data = mp_data; sh_dp = mp_dp; sh_blank = mp_blank; sh_raw = mp_raw;
               sh_rseg = mp_rseg;
            end
            mp_v = 1'b0;
         end
         m_k++;
         e_idx = (m_k / DIV) % D;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dp", 32'(dp), 32'(e_dp));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("scan_idx", 32'(scan_idx), 32'(e_idx));
   end

   task automatic timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: wait expired, expected condition not reached at %0t", nm, $time);
   endtask

   // Wait for the negedge where the model position within a frame equals pos.
   task automatic wait_phase(input int pos);
      int n = 0;
      do begin @(negedge clk); n++; end while (m_k % FR != pos && n < 200);
      if (n >= 200) timeout("wait_phase");
   endtask

   // Wait until the pins show the state of slot s at counter value c.
   task automatic wait_pins(input int s, input int c);
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(m_k > 0 && (m_k-1) % DIV == c && ((m_k-1) / DIV) % D == s) && n < 200);
      if (n >= 200) timeout("wait_pins");
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p,
                          input logic r, input logic [27:0] rs);
      data = d; blank_in = b; dp_in = p; raw_mode = r; raw_seg = rs; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      int fd_cnt;
      // 1: reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(an), 32'h0f);
      chk("rst_seg", 32'(seg), 32'h7f);
      chk("rst_dp", 32'(dp), 32'h1);
      rst = 1'b1;
      repeat (45) @(negedge clk);
      chk("noload_an", 32'(an), 32'h0f);

      // 2: hex 1234
      wait_phase(10);
      do_load(16'h1234, 4'b0000, 4'b0000, 1'b0, '0);
      wait_pins(0, 5);
      chk("s2_slot0_an", 32'(an), 32'h0e);
      chk("s2_slot0_seg", 32'(seg), 32'h19);
      wait_pins(3, 9);
      chk("s2_slot3_an", 32'(an), 32'h07);
      chk("s2_slot3_seg", 32'(seg), 32'h79);
      wait_pins(0, 1);
      chk("s2_blank_an", 32'(an), 32'h0f);
      fd_cnt = 0;
      repeat (80) begin @(negedge clk); if (frame_done) fd_cnt++; end
      chk("s2_fd_per_80", 32'(fd_cnt), 32'd2);

      // 3: mid-frame load keeps the current frame intact
      wait_phase(15);
      do_load(16'hABCD, 4'b0000, 4'b0000, 1'b0, '0);
      wait_pins(2, 5);
      chk("s3_old_digit2", 32'(seg), 32'h24);
      wait_pins(0, 5);
      chk("s3_new_d", 32'(seg), 32'h21);

      // 4: raw mode, dp and blanking
      wait_phase(10);
      do_load(16'h0000, 4'b0100, 4'b0001, 1'b1, {$urandom_range(0, 2**21-1), 7'b1000000});
      wait_pins(0, 5);
      chk("s4_an", 32'(an), 32'h0e);
      chk("s4_seg", 32'(seg), 32'h3f);
      chk("s4_dp", 32'(dp), 32'h0);
      wait_pins(2, 5);
      chk("s4_blank2", 32'(an), 32'h0f);

      // 5: load exactly at the frame boundary
      wait_phase(FR-1);
      do_load(16'hFFFF, 4'b0000, 4'b0000, 1'b0, '0);
      wait_pins(0, 5);
      chk("s5_F0", 32'(seg), 32'h0e);
      wait_pins(3, 5);
      chk("s5_F3", 32'(seg), 32'h0e);

      // 6: async reset during SHOW discards a pending load
      wait_phase(15);
      do_load(16'h5555, 4'b0000, 4'b0000, 1'b0, '0);
      wait_phase(25);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("s6_an", 32'(an), 32'h0f);
      chk("s6_seg", 32'(seg), 32'h7f);
      chk("s6_dp", 32'(dp), 32'h1);
      chk("s6_idx", 32'(scan_idx), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (90) @(negedge clk);
      chk("s6_dark", 32'(an), 32'h0f);

      // Random loads, including forced loads on the boundary cycle.
      for (int i = 0; i < 2400; i++) begin
         if ((m_k % FR == FR-1 && $urandom_range(0, 1) == 1) || $urandom_range(0, 11) == 0) begin
            data = 16'($urandom); blank_in = 4'($urandom); dp_in = 4'($urandom);
            raw_mode = 1'($urandom); raw_seg = 28'($urandom); load = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
      repeat (100) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
